lfsr_tpg: RTL and testbench
===========================

# lfsr_tpg

Programmable LFSR test-pattern generator for the BIST path. A runtime-configurable polynomial, seed and pattern count, plus a Fibonacci/Galois mode select, replace a fixed per-width tap table. A start/busy/done handshake bounds each pattern burst. Sits between the BIST controller (configuration, start) and the scan/CUT input drivers (pattern stream).

## Interface
- WIDTH, 32, register width in bits (≥2)
- CNT_W, 16, pattern-counter width
- RST_POLY, 32'h8020_0003, polynomial after reset (bit i = tap on r[i])
- RST_SEED, 1, seed after reset
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_we  in  1  latch cfg_poly/cfg_seed/cfg_count/cfg_mode; honoured only when busy=0
- cfg_poly  in  WIDTH  tap mask
- cfg_seed  in  WIDTH  start state
- cfg_count  in  CNT_W  patterns per burst
- cfg_mode  in  1  0 = Fibonacci, 1 = Galois
- start  in  1  begin burst; honoured only in IDLE
- hold  in  1  freeze register and counter during RUN
- abort  in  1  end burst without done
- pattern  out  WIDTH  current register value
- pattern_valid  out  1  pattern is a burst pattern
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse at burst end
- seed_err  out  1  sticky; last latched seed was all-zero

## Operation
- States: IDLE, RUN, DONE.
- IDLE→RUN on start: r ← seed, cnt ← count on the same edge. If count = 0, go IDLE→DONE instead; no pattern is emitted.
- RUN, hold=0: r ← next(r), cnt ← cnt−1. After the edge where cnt reaches 0, go to DONE.
- RUN, hold=1: r, cnt and state unchanged; pattern_valid stays 1, and the same pattern counts once.
- DONE→IDLE unconditionally. done=1 only in DONE.
- abort in RUN or DONE: go to IDLE next edge, done=0, r keeps its value. abort outranks start, hold and count expiry.
- Fibonacci: fb = XOR-reduce(r & poly); next = {fb, r[WIDTH-1:1]}.
- Galois: next = (r >> 1) ^ (r[0] ? poly : 0).
- Zero seed at cfg_we: latch seed = 1 and set seed_err. seed_err clears on the next cfg_we with a nonzero seed.
- cfg_we while busy=1 or in DONE: ignored entirely.
- The block performs no maximality check. The polynomial choice belongs to software.

## Timing
- Reset values: state=IDLE, r=RST_SEED, poly=RST_POLY, seed=RST_SEED, count=0, mode=0, pattern=RST_SEED, pattern_valid=0, busy=0, done=0, seed_err=0.
- All outputs are registered or decoded from registered state; there are no combinational input→output paths.
- First pattern (= seed) appears the cycle after start. With no hold, pattern k appears at cycle k after start, k = 1..count.
- done asserts at cycle count+1 after start (cycle 1 for count = 0). start is accepted again in the cycle after done.
- cfg_we and start in the same IDLE cycle: the burst uses the old configuration; the new values take effect for the next burst.
- Reset mid-burst: immediate return to reset values. There is no done pulse.

## Structure
- Package lfsr_tpg_pkg holds the state enum (IDLE, RUN, DONE) and the mode constants MODE_FIB=0 and MODE_GAL=1.
- Sub-module lfsr_step is purely combinational next-state logic: (r, poly, mode) → next. It is reusable by a future MISR.
- The top level holds the FSM, counter, configuration registers and seed-zero substitution.

## Test plan
- Fibonacci, WIDTH=4, poly 4'b0011, seed 4'b0001, count 15 → patterns 0001,1000,0100,0010,1001,1100,0110,1011,0101,1010,1101,1110,1111,0111,0011; done at cycle 16.
- Galois, WIDTH=4, poly 4'b1001, seed 0001, count 4 → 0001,1001,1101,1111; done at cycle 5.
- hold high for 3 cycles mid-burst, count 5 → the held pattern repeats for 3 extra cycles; exactly 5 distinct advances; done delayed by 3.
- count=0 start → pattern_valid never 1; done pulses the cycle after start. Zero seed → seed_err=1 and first pattern 0…01.
- abort at cycle 3 of count 10 → IDLE the next cycle, no done. cfg_we during RUN → no configuration change.
- reset_n low mid-RUN (asynchronous, between edges) → all outputs at reset values immediately. A new start then works normally.

Source files
------------

// File: rtl/lfsr_tpg_pkg.sv
// Shared types and constants for the LFSR test-pattern generator.
// Holds the burst FSM state encoding and the feedback-mode select values.
package lfsr_tpg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_GAL = 1'b1;

endpackage

// File: rtl/lfsr_step.sv
// One-step LFSR next-state function, Fibonacci or Galois form.
// Purely combinational so it can be shared with a future MISR.
module lfsr_step
    import lfsr_tpg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] poly_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] next_o
);

    always_comb begin
        if (mode_i == MODE_GAL) begin
            next_o = (r_i >> 1) ^ (r_i[0] ? poly_i : '0);
        end else begin
            next_o = {^(r_i & poly_i), r_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/lfsr_tpg.sv
// Programmable LFSR pattern generator: configuration registers, burst FSM
// with start/hold/abort control, pattern counter and zero-seed substitution.
module lfsr_tpg
    import lfsr_tpg_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               CNT_W    = 16,
    parameter logic [WIDTH-1:0] RST_POLY = WIDTH'(32'h8020_0003),
    parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_poly,
    input  logic [WIDTH-1:0] cfg_seed,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             hold,
    input  logic             abort,
    output logic [WIDTH-1:0] pattern,
    output logic             pattern_valid,
    output logic             busy,
    output logic             done,
    output logic             seed_err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] poly_q, poly_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             seed_err_q, seed_err_d;
    logic [WIDTH-1:0] r_next;

    lfsr_step #(.WIDTH(WIDTH)) u_step (
        .r_i    (r_q),
        .poly_i (poly_q),
        .mode_i (mode_q),
        .next_o (r_next)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    r_d     = seed_q;
                    cnt_d   = count_q;
                    state_d = (count_q == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    r_d   = r_next;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Configuration only moves in IDLE; a zero seed would lock the register,
    // so it is replaced by 1 and flagged.
    always_comb begin
        poly_d     = poly_q;
        seed_d     = seed_q;
        count_d    = count_q;
        mode_d     = mode_q;
        seed_err_d = seed_err_q;
        if (cfg_we && state_q == IDLE) begin
            poly_d  = cfg_poly;
            count_d = cfg_count;
            mode_d  = cfg_mode;
            if (cfg_seed == '0) begin
                seed_d     = WIDTH'(1);
                seed_err_d = 1'b1;
            end else begin
                seed_d     = cfg_seed;
                seed_err_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            r_q        <= RST_SEED;
            cnt_q      <= '0;
            poly_q     <= RST_POLY;
            seed_q     <= RST_SEED;
            count_q    <= '0;
            mode_q     <= MODE_FIB;
            seed_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            poly_q     <= poly_d;
            seed_q     <= seed_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
            seed_err_q <= seed_err_d;
        end
    end

    assign pattern       = r_q;
    assign pattern_valid = (state_q == RUN);
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign seed_err      = seed_err_q;

endmodule

// File: tb/tb_lfsr_tpg.sv
// Self-checking bench for lfsr_tpg: directed test-plan bursts plus randomized
// bursts checked against an arithmetic reference model of the LFSR rules.
module tb_lfsr_tpg;

    localparam int W  = 4;
    localparam int CW = 8;
    localparam logic [W-1:0] RPOLY = 4'b1001;
    localparam logic [W-1:0] RSEED = 4'b0001;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [W-1:0]  cfg_poly = '0;
    logic [W-1:0]  cfg_seed = '0;
    logic [CW-1:0] cfg_count = '0;
    logic          cfg_mode = 1'b0;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  pattern;
    logic          pattern_valid, busy, done, seed_err;

    lfsr_tpg #(.WIDTH(W), .CNT_W(CW), .RST_POLY(RPOLY), .RST_SEED(RSEED)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cfg_we        (cfg_we),
        .cfg_poly      (cfg_poly),
        .cfg_seed      (cfg_seed),
        .cfg_count     (cfg_count),
        .cfg_mode      (cfg_mode),
        .start         (start),
        .hold          (hold),
        .abort         (abort),
        .pattern       (pattern),
        .pattern_valid (pattern_valid),
        .busy          (busy),
        .done          (done),
        .seed_err      (seed_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the configuration the DUT should hold.
    logic [W-1:0] m_poly, m_seed;
    int           m_count;
    logic         m_mode, m_err;
    logic [W-1:0] seen_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Next state from the textual rules: shift right by halving, Fibonacci
    // feeds the tap parity into the top bit, Galois XORs poly when bit 0 left.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] r, input logic [W-1:0] p,
                                              input logic gal);
        int unsigned v, half, pu, par;
        v    = r;
        pu   = p;
        half = v / 2;
        if (gal) return W'((v % 2 == 1) ? (half ^ pu) : half);
        par = $countones(r & p) % 2;
        return W'(half + par * (2 ** (W - 1)));
    endfunction

    task automatic do_cfg(input logic [W-1:0] poly, input logic [W-1:0] seed,
                          input int count, input logic mode);
        cfg_poly  = poly;
        cfg_seed  = seed;
        cfg_count = CW'(count);
        cfg_mode  = mode;
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
        m_poly  = poly;
        m_count = count;
        m_mode  = mode;
        m_err   = (seed == '0);
        m_seed  = (seed == '0) ? W'(1) : seed;
        check("seed_err_cfg", seed_err, m_err);
    endtask

    // Runs one burst from IDLE; distinct patterns observed go into seen_q.
    task automatic run_burst(input int hold_pct, input int hold_at, input bit junk_cfg);
        logic [W-1:0] exp_r;
        int           adv, holds, forced;
        bit           fresh;
        seen_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m_count == 0) begin
            check("zero_valid", pattern_valid, 1'b0);
            check("zero_done", done, 1'b1);
            tick();
            check("zero_done_clr", done, 1'b0);
            check("zero_busy", busy, 1'b0);
            check("zero_valid2", pattern_valid, 1'b0);
            return;
        end
        exp_r = m_seed;
        adv = 0; holds = 0; forced = 0; fresh = 1'b1;
        while (adv < m_count) begin
            check("pattern", pattern, exp_r);
            check("valid", pattern_valid, 1'b1);
            check("busy", busy, 1'b1);
            check("done_early", done, 1'b0);
            if (fresh) seen_q.push_back(pattern);
            if (hold_at == adv && forced < 3) begin
                hold = 1'b1;
                forced++;
            end else begin
                hold = (holds < 8) && ($urandom_range(99) < hold_pct);
            end
            if (junk_cfg && adv == 1 && fresh) begin
                cfg_we    = 1'b1;
                cfg_poly  = ~m_poly;
                cfg_seed  = '0;
                cfg_count = CW'(1);
                cfg_mode  = ~m_mode;
            end
            tick();
            cfg_we = 1'b0;
            if (hold) begin
                holds++;
                fresh = 1'b0;
            end else begin
                exp_r = ref_next(exp_r, m_poly, m_mode);
                adv++;
                fresh = 1'b1;
            end
        end
        hold = 1'b0;
        check("done", done, 1'b1);
        check("valid_in_done", pattern_valid, 1'b0);
        check("busy_in_done", busy, 1'b0);
        if (junk_cfg) begin
            cfg_we   = 1'b1;
            cfg_seed = '0;
            cfg_poly = ~m_poly;
        end
        tick();
        cfg_we = 1'b0;
        check("done_clr", done, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("seed_err_hold", seed_err, m_err);
        if (hold_at >= 0) check("hold_count", forced, 3);
    endtask

    initial begin
        logic [W-1:0] fib_tab[15];
        logic [W-1:0] gal_tab[4];
        logic [W-1:0] exp_r;
        fib_tab = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100, 4'b0110, 4'b1011,
                    4'b0101, 4'b1010, 4'b1101, 4'b1110, 4'b1111, 4'b0111, 4'b0011};
        gal_tab = '{4'b0001, 4'b1001, 4'b1101, 4'b1111};

        // Reset values.
        tick();
        tick();
        check("rst_pattern", pattern, RSEED);
        check("rst_valid", pattern_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_seed_err", seed_err, 1'b0);
        #2 reset_n = 1'b1;
        tick();
        m_poly = RPOLY; m_seed = RSEED; m_count = 0; m_mode = 1'b0; m_err = 1'b0;

        // Fibonacci sequence from the test plan.
        do_cfg(4'b0011, 4'b0001, 15, 1'b0);
        run_burst(0, -1, 1'b0);
        check("fib_len", seen_q.size(), 15);
        for (int i = 0; i < 15; i++)
            if (i < seen_q.size()) check($sformatf("fib_tab%0d", i), seen_q[i], fib_tab[i]);

        // Galois sequence from the test plan.
        do_cfg(4'b1001, 4'b0001, 4, 1'b1);
        run_burst(0, -1, 1'b0);
        check("gal_len", seen_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < seen_q.size()) check($sformatf("gal_tab%0d", i), seen_q[i], gal_tab[i]);

        // Three-cycle hold mid-burst.
        do_cfg(4'b0011, 4'b0101, 5, 1'b0);
        run_burst(0, 2, 1'b0);
        check("hold_len", seen_q.size(), 5);

        // count = 0 with a zero seed, then zero seed with a real burst.
        do_cfg(4'b0011, 4'b0000, 0, 1'b0);
        run_burst(0, -1, 1'b0);
        do_cfg(4'b0011, 4'b0000, 3, 1'b0);
        run_burst(0, -1, 1'b0);
        check("zero_seed_first", seen_q.size() > 0 ? seen_q[0] : 4'hx, 4'b0001);
        do_cfg(4'b0011, 4'b0110, 3, 1'b0);

        // Abort at cycle 3 of a count-10 burst.
        do_cfg(4'b0011, 4'b0001, 10, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        exp_r = ref_next(ref_next(m_seed, m_poly, 1'b0), m_poly, 1'b0);
        check("abort_pre", pattern, exp_r);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_valid", pattern_valid, 1'b0);
        check("abort_keep", pattern, exp_r);
        tick();
        check("abort_no_done", done, 1'b0);

        // cfg_we during RUN and DONE is ignored; the next burst uses the old config.
        do_cfg(4'b1100, 4'b1010, 6, 1'b1);
        run_burst(0, -1, 1'b1);
        run_burst(0, -1, 1'b0);

        // cfg_we with start: burst uses old config, new one applies afterwards.
        cfg_poly = 4'b0011; cfg_seed = 4'b0111; cfg_count = CW'(3); cfg_mode = 1'b0;
        cfg_we = 1'b1;
        start  = 1'b1;
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
        check("same_cycle_old_seed", pattern, m_seed);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        m_poly = 4'b0011; m_seed = 4'b0111; m_count = 3; m_mode = 1'b0; m_err = 1'b0;
        run_burst(0, -1, 1'b0);

        // Asynchronous reset mid-RUN.
        do_cfg(4'b0011, 4'b0000, 8, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("arst_pattern", pattern, RSEED);
        check("arst_valid", pattern_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_seed_err", seed_err, 1'b0);
        #3 reset_n = 1'b1;
        tick();
        check("arst_no_done", done, 1'b0);
        m_poly = RPOLY; m_seed = RSEED; m_count = 0; m_mode = 1'b0; m_err = 1'b0;
        run_burst(0, -1, 1'b0);
        do_cfg(4'b1001, 4'b0011, 6, 1'b1);
        run_burst(0, -1, 1'b0);

        // Randomized bursts against the reference model.
        for (int n = 0; n < 25; n++) begin
            logic [W-1:0] rp, rs;
            rp = W'($urandom);
            rs = ($urandom_range(4) == 0) ? '0 : W'($urandom);
            do_cfg(rp, rs, int'($urandom_range(12)), logic'($urandom_range(1)));
            run_burst(25, -1, $urandom_range(3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
